// File: rtl/div_chk_pkg.sv
// rtl/div_chk_pkg.sv - shared types and constants for the divided-clock checker
package div_chk_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } chk_state_e;

  // Default width of the high/low counters and expected values
  localparam int DEF_CNT_W = 8;

  // Width of the match-streak counter; holds LOCK_CNT values up to 15
  localparam int STREAK_W = 4;

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - one-cycle history register with rise/fall decode
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic d_q;

  // Previous-cycle copy of din; din is already in the clk domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_q <= 1'b0;
    else        d_q <= din;
  end

  assign rise = din & ~d_q;
  assign fall = ~din & d_q;

endmodule

// File: rtl/div_clk_checker.sv
// rtl/div_clk_checker.sv - measures divided-clock high/low/period and tracks lock
module div_clk_checker
  import div_chk_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic [CNT_W:0]   meas_period,
  output logic             valid,
  output logic             mismatch,
  output logic             timeout,
  output logic             locked
);

  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [STREAK_W-1:0] LOCK_TGT = STREAK_W'(LOCK_CNT);

  chk_state_e          state;
  logic [CNT_W-1:0]    hi_cnt;
  logic [CNT_W-1:0]    lo_cnt;
  logic [STREAK_W-1:0] streak;
  logic                rise;
  logic                fall;
  logic                hit;
  logic [STREAK_W-1:0] streak_inc;

  edge_det u_edge_det (
    .clk   (clk),
    .reset (reset),
    .din   (div_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Exp values are sampled only here, at the terminating rise
  assign hit        = (hi_cnt == exp_high) && (lo_cnt == exp_low);
  assign streak_inc = (streak == LOCK_TGT) ? streak : streak + 1'b1;

  // Measurement FSM with counters, compare and lock tracking; all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      streak      <= '0;
      meas_high   <= '0;
      meas_low    <= '0;
      meas_period <= '0;
      valid       <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      valid    <= 1'b0;
      mismatch <= 1'b0;
      timeout  <= 1'b0;
      if (!enable) begin
        // Dropping enable abandons any partial period, even on a simultaneous rise
        state  <= IDLE;
        hi_cnt <= '0;
        lo_cnt <= '0;
        streak <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= WAIT_RISE;
            streak <= '0;
            locked <= 1'b0;
          end
          WAIT_RISE: begin
            if (rise) begin
              hi_cnt <= CNT_ONE;
              state  <= MEAS_HIGH;
            end
          end
          MEAS_HIGH: begin
            if (fall) begin
              lo_cnt <= CNT_ONE;
              state  <= MEAS_LOW;
            end else if (div_in) begin
              if (hi_cnt == CNT_MAX) begin
                timeout <= 1'b1;
                streak  <= '0;
                locked  <= 1'b0;
                state   <= WAIT_RISE;
              end else begin
                hi_cnt <= hi_cnt + CNT_ONE;
              end
            end
          end
          MEAS_LOW: begin
            if (rise) begin
              meas_high   <= hi_cnt;
              meas_low    <= lo_cnt;
              meas_period <= {1'b0, hi_cnt} + {1'b0, lo_cnt};
              valid       <= 1'b1;
              mismatch    <= ~hit;
              hi_cnt      <= CNT_ONE;
              state       <= MEAS_HIGH;
              if (hit) begin
                streak <= streak_inc;
                locked <= (streak_inc == LOCK_TGT);
              end else begin
                streak <= '0;
                locked <= 1'b0;
              end
            end else if (!div_in) begin
              if (lo_cnt == CNT_MAX) begin
                timeout <= 1'b1;
                streak  <= '0;
                locked  <= 1'b0;
                state   <= WAIT_RISE;
              end else begin
                lo_cnt <= lo_cnt + CNT_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_clk_checker.sv
// tb/tb_div_clk_checker.sv - self-checking bench for div_clk_checker
module tb_div_clk_checker;

  localparam int LOCK  = 4;
  localparam int SAT   = 255;

  typedef struct {
    int h;
    int l;
    int mis;
    int lck;
  } res_t;

  typedef struct {
    int hi;
    int lo;
    int eh;
    int el;
    int period;
    int mis;
    int lck;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       div_in = 1'b0;
  logic [7:0] exp_high = 8'd0;
  logic [7:0] exp_low = 8'd0;
  logic [7:0] meas_high;
  logic [7:0] meas_low;
  logic [8:0] meas_period;
  logic       valid;
  logic       mismatch;
  logic       timeout;
  logic       locked;

  int   checks = 0;
  int   errors = 0;
  res_t eq[$];
  int   pat_h[$];
  int   pat_l[$];
  int   m_streak = 0;
  int   tmo_exp = 0;
  int   tmo_seen = 0;
  bit   mon_en = 1'b0;
  int   last_period = 0;
  int   last_mis = 0;
  int   nvalid = 0;
  int   nmis = 0;
  res_t mon_r;
  vec_t vecs[6];

  div_clk_checker dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .div_in      (div_in),
    .exp_high    (exp_high),
    .exp_low     (exp_low),
    .meas_high   (meas_high),
    .meas_low    (meas_low),
    .meas_period (meas_period),
    .valid       (valid),
    .mismatch    (mismatch),
    .timeout     (timeout),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Result monitor on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (timeout) tmo_seen++;
      if (valid) begin
        nvalid++;
        last_period = int'(meas_period);
        last_mis    = int'(mismatch);
        if (mismatch) nmis++;
        chk("valid_expected", (eq.size() != 0) ? 1 : 0, 1);
        if (eq.size() != 0) begin
          mon_r = eq.pop_front();
          chk("meas_high", int'(meas_high), mon_r.h);
          chk("meas_low", int'(meas_low), mon_r.l);
          chk("meas_period", int'(meas_period), mon_r.h + mon_r.l);
          chk("mismatch", int'(mismatch), mon_r.mis);
          chk("locked", int'(locked), mon_r.lck);
        end
      end
    end
  end

  // Reference: each complete period either saturates (timeout, streak lost) or yields one result
  task automatic model();
    int h;
    int l;
    int mis;
    tmo_exp = 0;
    for (int i = 0; i < pat_h.size(); i++) begin
      h = pat_h[i];
      l = pat_l[i];
      if (h > SAT || l > SAT) begin
        tmo_exp++;
        m_streak = 0;
      end else begin
        mis = (h != int'(exp_high) || l != int'(exp_low)) ? 1 : 0;
        if (mis != 0) m_streak = 0;
        else if (m_streak < LOCK) m_streak++;
        eq.push_back('{h: h, l: l, mis: mis, lck: (m_streak == LOCK) ? 1 : 0});
      end
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    div_in = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input bit toggle_en);
    if (toggle_en) m_streak = 0;
    eq.delete();
    model();
    tmo_seen = 0;
    if (toggle_en) begin
      enable = 1'b0;
      drive(1'b0, 2);
      enable = 1'b1;
    end
    drive(1'b0, 3);
    for (int i = 0; i < pat_h.size(); i++) begin
      drive(1'b1, pat_h[i]);
      drive(1'b0, pat_l[i]);
    end
    drive(1'b1, 1);
    drive(1'b0, 4);
    chk("results_drained", eq.size(), 0);
    chk("timeouts", tmo_seen, tmo_exp);
    eq.delete();
  endtask

  task automatic set_pat(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pat_h.push_back(h);
      pat_l.push_back(l);
    end
  endtask

  initial begin
    vecs[0] = '{hi: 1,   lo: 1,   eh: 1,   el: 1,   period: 2,   mis: 0, lck: 1};
    vecs[1] = '{hi: 3,   lo: 5,   eh: 3,   el: 5,   period: 8,   mis: 0, lck: 1};
    vecs[2] = '{hi: 3,   lo: 5,   eh: 3,   el: 4,   period: 8,   mis: 1, lck: 0};
    vecs[3] = '{hi: 2,   lo: 2,   eh: 0,   el: 2,   period: 4,   mis: 1, lck: 0};
    vecs[4] = '{hi: 7,   lo: 1,   eh: 7,   el: 1,   period: 8,   mis: 0, lck: 1};
    vecs[5] = '{hi: 255, lo: 255, eh: 255, el: 255, period: 510, mis: 0, lck: 1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_mismatch", int'(mismatch), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_meas_high", int'(meas_high), 0);
    chk("rst_meas_low", int'(meas_low), 0);
    chk("rst_meas_period", int'(meas_period), 0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Table of steady patterns, five identical periods each
    foreach (vecs[k]) begin
      pat_h.delete();
      pat_l.delete();
      set_pat(vecs[k].hi, vecs[k].lo, 5);
      exp_high = 8'(vecs[k].eh);
      exp_low  = 8'(vecs[k].el);
      run(1'b1);
      chk("tbl_period", last_period, vecs[k].period);
      chk("tbl_mismatch", last_mis, vecs[k].mis);
      chk("tbl_locked", int'(locked), vecs[k].lck);
    end

    // One bad period inside a locked stream
    pat_h.delete();
    pat_l.delete();
    set_pat(3, 5, 5);
    set_pat(4, 5, 1);
    set_pat(3, 5, 4);
    exp_high = 8'd3;
    exp_low  = 8'd5;
    nmis = 0;
    run(1'b1);
    chk("bad_period_count", nmis, 1);
    chk("relocked", int'(locked), 1);

    // Saturation of high and of low, each followed by clean periods
    pat_h.delete();
    pat_l.delete();
    set_pat(3, 5, 1);
    set_pat(260, 5, 1);
    set_pat(3, 5, 1);
    set_pat(3, 300, 1);
    set_pat(3, 5, 1);
    nvalid = 0;
    run(1'b1);
    chk("sat_valid_count", nvalid, 3);

    // Enable dropped together with a rise in MEAS_LOW, then re-enabled mid-high
    pat_h.delete();
    pat_l.delete();
    set_pat(2, 3, 4);
    exp_high = 8'd2;
    exp_low  = 8'd3;
    run(1'b1);
    chk("pre_drop_locked", int'(locked), 1);
    nvalid = 0;
    div_in = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("drop_locked", int'(locked), 0);
    chk("drop_valid", int'(valid), 0);
    chk("drop_meas_high", int'(meas_high), 2);
    chk("drop_meas_low", int'(meas_low), 3);
    m_streak = 0;
    drive(1'b1, 2);
    enable = 1'b1;
    drive(1'b1, 3);
    pat_h.delete();
    pat_l.delete();
    set_pat(2, 3, 2);
    run(1'b0);
    chk("reenable_valid_count", nvalid, 2);

    // Randomized periods against the reference model
    for (int r = 0; r < 8; r++) begin
      int n;
      int eh;
      int el;
      pat_h.delete();
      pat_l.delete();
      eh = $urandom_range(1, 4);
      el = $urandom_range(1, 4);
      n  = $urandom_range(6, 12);
      exp_high = 8'(eh);
      exp_low  = 8'(el);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          pat_h.push_back(eh);
          pat_l.push_back(el);
        end else begin
          pat_h.push_back($urandom_range(1, 5));
          pat_l.push_back($urandom_range(1, 5));
        end
      end
      run(1'b1);
    end

    // Asynchronous reset in the middle of a running measurement
    mon_en = 1'b0;
    enable = 1'b1;
    exp_high = 8'd1;
    exp_low  = 8'd1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_mismatch", int'(mismatch), 0);
    chk("async_timeout", int'(timeout), 0);
    chk("async_locked", int'(locked), 0);
    chk("async_meas_high", int'(meas_high), 0);
    chk("async_meas_low", int'(meas_low), 0);
    chk("async_meas_period", int'(meas_period), 0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    m_streak = 0;
    mon_en   = 1'b1;
    nvalid   = 0;
    pat_h.delete();
    pat_l.delete();
    set_pat(1, 1, 5);
    run(1'b0);
    chk("post_reset_valid_count", nvalid, 5);
    chk("post_reset_locked", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
